// File: rtl/tone_pkg.sv
// Shared types and constants for the key-driven square-wave tone generator.
package tone_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned PHASE_W  = 17;
  localparam int unsigned AMP_W    = 15;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  // Half-period in CLOCK_50 cycles, index 0 = q (C4) .. 15 = h (D6).
  localparam logic [PHASE_W-1:0] HALF_PERIOD [NUM_KEYS] = '{
    17'd95556, 17'd85131, 17'd75843, 17'd71586,
    17'd63776, 17'd56818, 17'd50619, 17'd47778,
    17'd42566, 17'd37922, 17'd35793, 17'd31888,
    17'd28409, 17'd25310, 17'd23889, 17'd21282
  };

endpackage : tone_pkg

// File: rtl/tone_envelope.sv
// Amplitude envelope: FSM plus saturating amp register, advanced once per sample tick.
// TONE_ENVELOPE_EN selects linear ATTACK/RELEASE ramps; otherwise amp switches between 0 and AMP_MAX.
module tone_envelope
  import tone_pkg::*;
#(
  parameter int unsigned AMP_MAX      = 8192,
  parameter int unsigned ATTACK_STEP  = 64,
  parameter int unsigned RELEASE_STEP = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             key_any_i,
  output logic [AMP_W-1:0] amp_o,
  output env_state_t       state_o
);

`ifdef TONE_ENVELOPE_EN
  localparam bit ENV_EN = 1'b1;
`else
  localparam bit ENV_EN = 1'b0;
`endif

  // Without ramps every step is full scale, so a single tick lands on AMP_MAX or 0
  // and only IDLE and SUSTAIN are ever reached.
  localparam int unsigned UP_STEP = ENV_EN ? ATTACK_STEP : AMP_MAX;
  localparam int unsigned DN_STEP = ENV_EN ? RELEASE_STEP : AMP_MAX;

  env_state_t       state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [AMP_W:0]   up_sum_c;
  logic [AMP_W-1:0] amp_up_c, amp_dn_c;

  always_comb begin
    up_sum_c = {1'b0, amp_q} + (AMP_W+1)'(UP_STEP);
    amp_up_c = (up_sum_c >= (AMP_W+1)'(AMP_MAX)) ? AMP_W'(AMP_MAX) : up_sum_c[AMP_W-1:0];
    amp_dn_c = (amp_q <= AMP_W'(DN_STEP)) ? '0 : amp_q - AMP_W'(DN_STEP);
  end

  // The tick that changes state also applies the new state's ramp step.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    if (tick_i) begin
      unique case (state_q)
        ENV_IDLE: begin
          if (key_any_i) begin
            amp_d   = amp_up_c;
            state_d = (amp_up_c == AMP_W'(AMP_MAX)) ? ENV_SUSTAIN : ENV_ATTACK;
          end
        end
        ENV_ATTACK, ENV_RELEASE: begin
          if (key_any_i) begin
            amp_d   = amp_up_c;
            state_d = (amp_up_c == AMP_W'(AMP_MAX)) ? ENV_SUSTAIN : ENV_ATTACK;
          end else begin
            amp_d   = amp_dn_c;
            state_d = (amp_dn_c == '0) ? ENV_IDLE : ENV_RELEASE;
          end
        end
        ENV_SUSTAIN: begin
          if (!key_any_i) begin
            amp_d   = amp_dn_c;
            state_d = (amp_dn_c == '0) ? ENV_IDLE : ENV_RELEASE;
          end
        end
        default: begin
          state_d = ENV_IDLE;
          amp_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ENV_IDLE;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
    end
  end

  assign amp_o   = amp_q;
  assign state_o = state_q;

endmodule : tone_envelope

// File: rtl/key_tone_gen.sv
// Priority-selected square-wave tone with envelope, delivered as signed samples over valid/ready.
// Build with TONE_ENVELOPE_EN defined for ATTACK/RELEASE ramps; default is on/off amplitude.
module key_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 1042,
  parameter int unsigned AMP_MAX      = 8192,
  parameter int unsigned ATTACK_STEP  = 64,
  parameter int unsigned RELEASE_STEP = 32
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_KEYS-1:0]        key_vec,
  output logic signed [AMP_W:0]      sample,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       note_active,
  output logic [IDX_W-1:0]           note_idx,
  output logic                       overrun
);

  localparam int unsigned SAMPLE_W = AMP_W + 1;
  localparam int unsigned TICK_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [NUM_KEYS-1:0]        key_q;
  logic [IDX_W-1:0]           note_idx_q, note_idx_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic                       pol_q, pol_d;
  logic [TICK_W-1:0]          tick_q, tick_d;
  logic                       load_q;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic [IDX_W-1:0]           sel_idx_c;
  logic                       key_any_c;
  logic                       note_chg_c;
  logic                       tick_c;
  logic [PHASE_W-1:0]         half_c;
  logic signed [SAMPLE_W-1:0] amp_pos_c, sample_new_c;

  logic [AMP_W-1:0]           env_amp;
  env_state_t                 env_state;

  // Lowest set bit first so the highest bit (q) overwrites and wins.
  always_comb begin
    sel_idx_c = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (key_q[i]) sel_idx_c = IDX_W'(int'(NUM_KEYS) - 1 - i);
    end
    key_any_c = |key_q;
  end

  // note_idx only follows held keys, so a released note decays at its own pitch.
  always_comb begin
    note_chg_c = key_any_c && (sel_idx_c != note_idx_q);
    note_idx_d = key_any_c ? sel_idx_c : note_idx_q;
    half_c     = HALF_PERIOD[note_idx_q];
    phase_d    = phase_q + 1'b1;
    pol_d      = pol_q;
    if (note_chg_c) begin
      phase_d = '0;
      pol_d   = 1'b1;
    end else if (phase_q >= half_c - 1'b1) begin
      phase_d = '0;
      pol_d   = ~pol_q;
    end
  end

  always_comb begin
    tick_c = (tick_q == TICK_W'(SAMPLE_DIV - 1));
    tick_d = tick_c ? '0 : tick_q + 1'b1;
  end

  tone_envelope #(
    .AMP_MAX      (AMP_MAX),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP)
  ) u_envelope (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .tick_i    (tick_c),
    .key_any_i (key_any_c),
    .amp_o     (env_amp),
    .state_o   (env_state)
  );

  // load_q marks the cycle after a tick, when env_amp already holds the updated value.
  always_comb begin
    amp_pos_c    = SAMPLE_W'(env_amp);
    sample_new_c = pol_q ? amp_pos_c : -amp_pos_c;
    sample_d     = sample_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    if (load_q) begin
      sample_d = sample_new_c;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_q      <= '0;
      note_idx_q <= '0;
      phase_q    <= '0;
      pol_q      <= 1'b1;
      tick_q     <= '0;
      load_q     <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      key_q      <= key_vec;
      note_idx_q <= note_idx_d;
      phase_q    <= phase_d;
      pol_q      <= pol_d;
      tick_q     <= tick_d;
      load_q     <= tick_c;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign note_idx     = note_idx_q;
  assign overrun      = overrun_q;
  assign note_active  = (env_state != ENV_IDLE);

endmodule : key_tone_gen

// File: tb/tb_key_tone_gen.sv
// Self-checking bench for key_tone_gen: tick-level envelope scoreboard plus hand-written corner sequences.
module tb_key_tone_gen;

  localparam int unsigned DIV     = 16;
  localparam int unsigned AMP_MAX = 8192;
  localparam int unsigned ATK     = 64;
  localparam int unsigned REL     = 32;
  localparam int          HP_H    = 21282;

`ifdef TONE_ENVELOPE_EN
  localparam bit ENV = 1'b1;
`else
  localparam bit ENV = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [15:0]        key_vec;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               sample_ready;
  logic               note_active;
  logic [3:0]         note_idx;
  logic               overrun;

  key_tone_gen #(
    .SAMPLE_DIV   (DIV),
    .AMP_MAX      (AMP_MAX),
    .ATTACK_STEP  (ATK),
    .RELEASE_STEP (REL)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .key_vec      (key_vec),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .note_active  (note_active),
    .note_idx     (note_idx),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_amp = 0;
  int m_st  = 0;  // 0 idle, 1 attack, 2 sustain, 3 release
  logic signed [15:0] last_sample;

  typedef struct {
    logic [15:0] kv;
    int          ticks;
    int          idx;
    int          act;
    int          amp;
  } vec_t;
  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int iabs(input logic signed [15:0] s);
    int v;
    v = s;
    return (v < 0) ? -v : v;
  endfunction

  // Envelope behaviour at one sample tick, straight from the operating description.
  task automatic model_tick(input bit key);
`ifdef TONE_ENVELOPE_EN
    if (key) begin
      if (m_st != 2) begin
        m_amp = (m_amp + int'(ATK) >= int'(AMP_MAX)) ? int'(AMP_MAX) : m_amp + int'(ATK);
        m_st  = (m_amp == int'(AMP_MAX)) ? 2 : 1;
      end
    end else if (m_st != 0) begin
      m_amp = (m_amp <= int'(REL)) ? 0 : m_amp - int'(REL);
      m_st  = (m_amp == 0) ? 0 : 3;
    end
`else
    m_amp = key ? int'(AMP_MAX) : 0;
    m_st  = key ? 2 : 0;
`endif
  endtask

  task automatic wait_xfer(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(2*DIV + 8) && !ok; i++) begin
      step();
      if (sample_valid && sample_ready) begin
        ok = 1'b1;
        last_sample = sample;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no sample transfer within %0d cycles", name, 2*DIV + 8);
    end
  endtask

  task automatic run_ticks(input logic [15:0] kv, input int n);
    bit ok;
    int e;
    key_vec = kv;
    for (int t = 0; t < n; t++) begin
      model_tick(kv != 16'h0);
      exp_q.push_back(m_amp);
      wait_xfer("sb_wait", ok);
      e = exp_q.pop_front();
      if (ok) check("sb_amp", iabs(last_sample), e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, neg_at, pos_at, first_sign, stable;
    logic signed [15:0] s1;

    tbl[0] = '{16'h8000, 128, 0,  1,              8192};
    tbl[1] = '{16'h8000, 10,  0,  1,              8192};
    tbl[2] = '{16'h0000, 128, 0,  ENV ? 1 : 0,    ENV ? 4096 : 0};
    tbl[3] = '{16'h0000, 128, 0,  0,              0};
    tbl[4] = '{16'h0001, 1,   15, 1,              ENV ? 64 : 8192};
    tbl[5] = '{16'h8100, 20,  0,  1,              ENV ? 1344 : 8192};
    tbl[6] = '{16'h0100, 5,   7,  1,              ENV ? 1664 : 8192};

    rst = 1'b1;
    key_vec = 16'h0;
    sample_ready = 1'b1;
    step(); step(); step();
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_active", int'(note_active), 0);
    check("rst_idx", int'(note_idx), 0);
    check("rst_overrun", int'(overrun), 0);

    key_vec = 16'h8000;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_ticks(tbl[v].kv, tbl[v].ticks);
      check($sformatf("tbl%0d_idx", v), int'(note_idx), tbl[v].idx);
      check($sformatf("tbl%0d_active", v), int'(note_active), tbl[v].act);
      check($sformatf("tbl%0d_amp", v), iabs(last_sample), tbl[v].amp);
    end

    // Note change to h: polarity restarts positive, then toggles every HP_H cycles.
    key_vec = 16'h0001;
    c = 0; neg_at = -1; pos_at = -1; first_sign = 0;
    while (pos_at < 0 && c < 3*HP_H) begin
      step();
      c++;
      if (sample_valid && sample_ready) begin
        if (first_sign == 0) first_sign = (sample > 0) ? 1 : -1;
        if (sample < 0 && neg_at < 0) neg_at = c;
        else if (sample > 0 && neg_at >= 0) pos_at = c;
      end
    end
    check("pol_first_positive", first_sign, 1);
    check("pol_idx", int'(note_idx), 15);
    check_rng("pol_first_toggle", neg_at, HP_H, HP_H + int'(DIV) + 4);
    check_rng("pol_half_period", pos_at - neg_at, HP_H - int'(DIV), HP_H + int'(DIV));

    // Codec stalls across two ticks while the note releases.
    step();
    sample_ready = 1'b0;
    key_vec = 16'h0;
    ok = 1'b0;
    for (int i = 0; i < int'(2*DIV + 8) && !ok; i++) begin
      step();
      if (sample_valid) ok = 1'b1;
    end
    check("ovr_first_load", int'(ok), 1);
    s1 = sample;
    check("ovr_first_amp", iabs(s1), ENV ? 8160 : 0);
    check("ovr_not_yet", int'(overrun), 0);
    stable = 1;
    for (int i = 0; i < int'(DIV) - 4; i++) begin
      step();
      if (!sample_valid || sample != s1 || overrun) stable = 0;
    end
    check("ovr_hold_stable", stable, 1);
    ok = 1'b0;
    for (int i = 0; i < int'(2*DIV) && !ok; i++) begin
      step();
      if (overrun) ok = 1'b1;
    end
    check("ovr_set", int'(overrun), 1);
    check("ovr_valid", int'(sample_valid), 1);
    check("ovr_second_amp", iabs(sample), ENV ? 8128 : 0);
    sample_ready = 1'b1;
    step();
    check("ovr_drain_valid", int'(sample_valid), 0);
    check("ovr_sticky", int'(overrun), 1);

    // Fresh attack, then asynchronous reset in the middle of a cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_amp = 0;
    m_st = 0;
    exp_q.delete();
    run_ticks(16'h8000, 47);
    check("pre_rst_amp", iabs(last_sample), ENV ? 3008 : 8192);
    #5;
    rst = 1'b1;
    #1;
    check("arst_sample", int'(sample), 0);
    check("arst_valid", int'(sample_valid), 0);
    check("arst_active", int'(note_active), 0);
    check("arst_idx", int'(note_idx), 0);
    check("arst_overrun", int'(overrun), 0);
    step();
    rst = 1'b0;
    for (int k = 1; k < int'(DIV); k++) step();
    step();
    check("post_rst_no_early", int'(sample_valid), 0);
    step();
    check("post_rst_first_valid", int'(sample_valid), 1);
    check("post_rst_amp", iabs(sample), ENV ? 64 : 8192);
    check("post_rst_active", int'(note_active), 1);
    check("post_rst_idx", int'(note_idx), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_key_tone_gen
